// File: rtl/fp_fixed_conv_pipe.sv
// fp_fixed_conv_pipe
//   Two-stage converter between IEEE-754 single precision and a sign-magnitude
//   fixed-point word {sign, int[INT_W-1:0], frac[FRAC_W-1:0]}, LSB-aligned in
//   32 bits.
//   Stage 1 unpacks the operand and aligns the magnitude. It keeps a guard bit
//   and a sticky bit for the rounding step.
//   Stage 2 rounds, saturates and packs the result.
//   Optional macro FPFX_ROUND_EN:
//     - defined: round to nearest, ties to even.
//     - undefined: truncate toward zero.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid_i   input transaction valid
//   in_ready_o   block accepts input this cycle
//   dir_i        0 = float -> fixed, 1 = fixed -> float
//   data_i       operand (32 bits)
//   out_valid_o  result valid
//   out_ready_i  consumer accepts result
//   data_o       result (32 bits)
//   dir_o        direction of the presented result
//   ovf_o        float -> fixed saturated
//   nan_o        float -> fixed input was NaN
module fp_fixed_conv_pipe #(
    parameter int INT_W  = 1,
    parameter int FRAC_W = 19
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        dir_i,
    input  logic [31:0] data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] data_o,
    output logic        dir_o,
    output logic        ovf_o,
    output logic        nan_o
);

    localparam int MW = INT_W + FRAC_W;
    // Shift that turns the 24-bit significand into the fixed magnitude.
    localparam logic signed [10:0] SH_BIAS  = 11'(FRAC_W - 150);
    // Any left shift at or above this puts the leading one at or past 2^MW.
    localparam logic signed [10:0] OVF_SH   = 11'(MW - 23);
    localparam logic [7:0]         EXP_BIAS = 8'(127 - FRAC_W);
    localparam logic [31:0]        MAG_MAX  = 32'((64'd1 << MW) - 64'd1);

    function automatic logic round_up(input logic lsb, input logic grd, input logic stk);
`ifdef FPFX_ROUND_EN
        return grd & (stk | lsb);
`else
        // Truncation never increments.
        return 1'b0 & (lsb | grd | stk);
`endif
    endfunction

    function automatic logic [31:0] pack_fx(input logic s, input logic [31:0] mag);
        logic [31:0] w;
        w     = mag & MAG_MAX;
        w[MW] = s;
        return w;
    endfunction

    function automatic logic [4:0] lead_one(input logic [31:0] v);
        logic [4:0] p;
        p = '0;
        for (int i = 0; i < 32; i++)
            if (v[i]) p = 5'(i);
        return p;
    endfunction

    // Handshake: stage 2 can take new data when it is empty or being drained.
    logic vld_p1, vld_p2, adv2;
    assign adv2       = !vld_p2 || out_ready_i;
    assign in_ready_o = !vld_p1 || adv2;

    // ---- stage 1: unpack / align ----
    logic              sign_p0, grd_p0, stk_p0, ovf_p0, nan_p0;
    logic [31:0]       mag_p0, mag_in, norm;
    logic [7:0]        exp_p0, exp_f;
    logic [23:0]       sig24;
    logic signed [10:0] shift_s, rsh;
    logic [47:0]       ext;
    logic [4:0]        lead;

    always_comb begin
        sign_p0 = 1'b0;
        grd_p0  = 1'b0;
        stk_p0  = 1'b0;
        ovf_p0  = 1'b0;
        nan_p0  = 1'b0;
        mag_p0  = '0;
        exp_p0  = '0;
        exp_f   = data_i[30:23];
        sig24   = {1'b1, data_i[22:0]};
        shift_s = $signed({3'b000, exp_f}) + SH_BIAS;
        rsh     = -shift_s;
        ext     = '0;
        mag_in  = 32'(data_i[MW-1:0]);
        norm    = '0;
        lead    = '0;
        if (!dir_i) begin
            sign_p0 = data_i[31];
            if (exp_f == 8'hFF) begin
                nan_p0 = |data_i[22:0];
                ovf_p0 = ~|data_i[22:0];
            end else if (exp_f == 8'h00) begin
                // zero and denormals flush to magnitude 0
                mag_p0 = '0;
            end else if (shift_s >= OVF_SH) begin
                ovf_p0 = 1'b1;
            end else if (shift_s >= 11'sd0) begin
                mag_p0 = {8'b0, sig24} << shift_s[2:0];
            end else begin
                // Beyond 47 the guard bit is 0, so the value truncates to 0 anyway.
                if (rsh <= 11'sd47)
                    ext = {sig24, 24'b0} >> rsh[5:0];
                mag_p0 = {8'b0, ext[47:24]};
                grd_p0 = ext[23];
                stk_p0 = |ext[22:0];
            end
        end else begin
            sign_p0 = data_i[MW];
            if (mag_in != '0) begin
                lead   = lead_one(mag_in);
                norm   = mag_in << (5'd31 - lead);
                mag_p0 = {9'b0, norm[30:8]};
                grd_p0 = norm[7];
                stk_p0 = |norm[6:0];
                exp_p0 = EXP_BIAS + 8'(lead);
            end
        end
    end

    logic              dir_p1, sign_p1, grd_p1, stk_p1, ovf_p1, nan_p1;
    logic [31:0]       mag_p1;
    logic [7:0]        exp_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else if (in_ready_o)
            vld_p1 <= in_valid_i;
    end

    always_ff @(posedge clk) begin
        if (in_valid_i && in_ready_o) begin
            dir_p1  <= dir_i;
            sign_p1 <= sign_p0;
            grd_p1  <= grd_p0;
            stk_p1  <= stk_p0;
            ovf_p1  <= ovf_p0;
            nan_p1  <= nan_p0;
            mag_p1  <= mag_p0;
            exp_p1  <= exp_p0;
        end
    end

    // ---- stage 2: round / saturate / pack ----
    logic        inc, sat, res_ovf, res_nan;
    logic [31:0] rnd, res_data;
    logic [24:0] sig25;
    logic [22:0] mant;

    always_comb begin
        inc      = round_up(mag_p1[0], grd_p1, stk_p1);
        rnd      = mag_p1 + 32'(inc);
        sig25    = {2'b01, mag_p1[22:0]} + 25'(inc);
        mant     = sig25[24] ? sig25[23:1] : sig25[22:0];
        sat      = nan_p1 || ovf_p1 || ((rnd >> MW) != '0);
        res_ovf  = 1'b0;
        res_nan  = 1'b0;
        res_data = '0;
        if (!dir_p1) begin
            res_ovf  = sat && !nan_p1;
            res_nan  = nan_p1;
            res_data = pack_fx(sign_p1, sat ? MAG_MAX : rnd);
        end else begin
            // Zero magnitude arrives as exp 0 / mantissa 0 and packs to signed zero.
            res_data = {sign_p1, exp_p1 + 8'(sig25[24]), mant};
        end
    end

    logic [31:0] data_p2;
    logic        dir_p2, ovf_p2, nan_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p2 <= 1'b0;
        else if (adv2)
            vld_p2 <= vld_p1;
    end

    always_ff @(posedge clk) begin
        if (adv2 && vld_p1) begin
            data_p2 <= res_data;
            dir_p2  <= dir_p1;
            ovf_p2  <= res_ovf;
            nan_p2  <= res_nan;
        end
    end

    // Outputs read as zero whenever nothing valid is presented, including reset.
    assign out_valid_o = vld_p2;
    assign data_o      = vld_p2 ? data_p2 : '0;
    assign dir_o       = vld_p2 & dir_p2;
    assign ovf_o       = vld_p2 & ovf_p2;
    assign nan_o       = vld_p2 & nan_p2;

endmodule

// File: tb/tb_fp_fixed_conv_pipe.sv
// Testbench for fp_fixed_conv_pipe (INT_W=1, FRAC_W=19).
// Scoreboard of model expectations plus literal expectations for directed vectors.
module tb_fp_fixed_conv_pipe;

    localparam int INT_W  = 1;
    localparam int FRAC_W = 19;
    localparam int MW     = INT_W + FRAC_W;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_i, in_ready_o, dir_i, out_valid_o, out_ready_i;
    logic        dir_o, ovf_o, nan_o;
    logic [31:0] data_i, data_o;

    fp_fixed_conv_pipe #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .dir_i(dir_i), .data_i(data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .data_o(data_o), .dir_o(dir_o), .ovf_o(ovf_o), .nan_o(nan_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dir;
        logic [33:0] m;      // {ovf, nan, data}
        bit          has_lit;
        logic [31:0] ld;
        logic        lo;
        logic        ln;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---- reference model from the number formats ----
    function automatic logic [31:0] fx_word(input bit s, input longint mag);
        return 32'(mag) | (32'(s) << MW);
    endfunction

    function automatic logic [33:0] model_f2x(input logic [31:0] d);
        bit     s;
        int     e, k, sh;
        longint sig, qv, r, half, lim, maxm;
        s    = d[31];
        e    = int'(d[30:23]);
        lim  = longint'(1) << MW;
        maxm = lim - 1;
        if (e == 255) begin
            if (d[22:0] != 0) return {2'b01, fx_word(s, maxm)};
            return {2'b10, fx_word(s, maxm)};
        end
        if (e == 0) return {2'b00, fx_word(s, 0)};
        sig = longint'(d[22:0]) + (longint'(1) << 23);
        k   = e - 150 + FRAC_W;
        if (k > 31) qv = lim;
        else if (k >= 0) qv = sig << k;
        else begin
            sh = -k;
            if (sh >= 60) qv = 0;
            else begin
                qv   = sig >> sh;
                r    = sig - (qv << sh);
                half = longint'(1) << (sh - 1);
`ifdef FPFX_ROUND_EN
                if (r > half || (r == half && qv[0])) qv = qv + 1;
`else
                if (r < 0 || half < 0) qv = 0;
`endif
            end
        end
        if (qv >= lim) return {2'b10, fx_word(s, maxm)};
        return {2'b00, fx_word(s, qv)};
    endfunction

    function automatic logic [31:0] model_x2f(input logic [31:0] d);
        bit     s;
        int     p, sh;
        longint mag, m, qv, r, half;
        s   = d[MW];
        mag = longint'(d[MW-1:0]);
        if (mag == 0) return {s, 31'b0};
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        if (p <= 23) m = mag << (23 - p);
        else begin
            sh   = p - 23;
            qv   = mag >> sh;
            r    = mag - (qv << sh);
            half = longint'(1) << (sh - 1);
`ifdef FPFX_ROUND_EN
            if (r > half || (r == half && qv[0])) qv = qv + 1;
`endif
            m = qv;
            if (m >= (longint'(1) << 24)) begin
                m = m >> 1;
                p = p + 1;
            end
        end
        return {s, 8'(p - FRAC_W + 127), 23'(m)};
    endfunction

    // ---- one clock of stimulus; pushes the expectation when accepted ----
    task automatic cycle(input bit v, input bit dr, input logic [31:0] d, input bit ordy,
                         input bit hl, input logic [31:0] ld, input bit lo, input bit ln,
                         output bit acc, output bit ir);
        exp_t e;
        @(negedge clk);
        in_valid_i  = v;
        dir_i       = dr;
        data_i      = d;
        out_ready_i = ordy;
        #1;
        ir  = in_ready_o;
        acc = v && ir;
        if (acc) begin
            e.dir     = dr;
            e.m       = dr ? {2'b00, model_x2f(d)} : model_f2x(d);
            e.has_lit = hl;
            e.ld      = ld;
            e.lo      = lo;
            e.ln      = ln;
            q.push_back(e);
        end
    endtask

    task automatic send(input bit dr, input logic [31:0] d, input bit hl,
                        input logic [31:0] ld, input bit lo, input bit ln);
        bit acc, ir;
        int n;
        n = 0;
        do begin
            cycle(1'b1, dr, d, 1'b1, hl, ld, lo, ln, acc, ir);
            n++;
        end while (!acc && n < 20);
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        bit acc, ir;
        for (int k = 0; k < 30 && q.size() != 0; k++)
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, acc, ir);
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, acc, ir);
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    // ---- compare process: one check set per consumed result, hold check on stalls ----
    initial begin
        bit          have_prev;
        logic [31:0] p_data;
        logic        p_dir, p_ovf, p_nan;
        exp_t        e;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                have_prev = 1'b0;
                continue;
            end
            if (have_prev) begin
                chk("hold_valid", 32'(out_valid_o), 32'd1);
                chk("hold_data", data_o, p_data);
                chk("hold_flags", {29'b0, dir_o, ovf_o, nan_o}, {29'b0, p_dir, p_ovf, p_nan});
            end
            if (out_valid_o && out_ready_i) begin
                n_out++;
                if (q.size() == 0) begin
                    chk("unexpected_output", data_o, 32'hxxxxxxxx);
                end else begin
                    e = q.pop_front();
                    chk("model_data", data_o, e.m[31:0]);
                    chk("model_ovf", 32'(ovf_o), 32'(e.m[33]));
                    chk("model_nan", 32'(nan_o), 32'(e.m[32]));
                    chk("model_dir", 32'(dir_o), 32'(e.dir));
                    if (e.has_lit) begin
                        chk("lit_data", data_o, e.ld);
                        chk("lit_flags", {30'b0, ovf_o, nan_o}, {30'b0, e.lo, e.ln});
                    end
                end
            end
            have_prev = out_valid_o && !out_ready_i;
            p_data    = data_o;
            p_dir     = dir_o;
            p_ovf     = ovf_o;
            p_nan     = nan_o;
        end
    end

    // ---- main stimulus ----
    initial begin
        bit acc, ir;
        int i, base;
        logic [31:0] sv [6];
        bit          sd [6];

        rst_n = 1'b0; in_valid_i = 1'b0; dir_i = 1'b0; data_i = '0; out_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_flags", {29'b0, dir_o, ovf_o, nan_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", 32'(in_ready_o), 32'd1);

        // literal pins on the model itself
        chk("pin_f2x_1p5", model_f2x(32'h3FC00000)[31:0], 32'h000C0000);
        chk("pin_f2x_neg", model_f2x(32'hBE800000)[31:0], 32'h00120000);
        chk("pin_x2f_1p5", model_x2f(32'h000C0000), 32'h3FC00000);
        chk("pin_x2f_max", model_x2f(32'h000FFFFF), 32'h3FFFFFF0);
        chk("pin_f2x_ovf", 32'(model_f2x(32'h40000000)[33]), 32'd1);

        // directed vectors, back to back
        send(1'b0, 32'h3FC00000, 1'b1, 32'h000C0000, 1'b0, 1'b0);
        send(1'b1, 32'h000C0000, 1'b1, 32'h3FC00000, 1'b0, 1'b0);
        send(1'b0, 32'hBE800000, 1'b1, 32'h00120000, 1'b0, 1'b0);
        send(1'b0, 32'h40000000, 1'b1, 32'h000FFFFF, 1'b1, 1'b0);
        send(1'b0, 32'h7FC00000, 1'b1, 32'h000FFFFF, 1'b0, 1'b1);
`ifdef FPFX_ROUND_EN
        send(1'b0, 32'h36400000, 1'b1, 32'h00000002, 1'b0, 1'b0);
        send(1'b0, 32'h3FFFFFFF, 1'b1, 32'h000FFFFF, 1'b1, 1'b0);
`else
        send(1'b0, 32'h36400000, 1'b1, 32'h00000001, 1'b0, 1'b0);
        send(1'b0, 32'h3FFFFFFF, 1'b1, 32'h000FFFFF, 1'b0, 1'b0);
`endif
        send(1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b0);
        send(1'b0, 32'h80000000, 1'b1, 32'h00100000, 1'b0, 1'b0);
        send(1'b0, 32'h00000001, 1'b1, 32'h00000000, 1'b0, 1'b0);
        send(1'b0, 32'hFF800000, 1'b1, 32'h001FFFFF, 1'b1, 1'b0);
        send(1'b1, 32'h00100000, 1'b1, 32'h80000000, 1'b0, 1'b0);
        send(1'b1, 32'h000FFFFF, 1'b1, 32'h3FFFFFF0, 1'b0, 1'b0);
        send(1'b1, 32'h00000001, 1'b1, 32'h36000000, 1'b0, 1'b0);
        send(1'b1, 32'h001C0000, 1'b1, 32'hBFC00000, 1'b0, 1'b0);
        drain();

        // stream of 6 with a 3-cycle consumer stall
        sv = '{32'h3F800000, 32'h000A0000, 32'hC0400000, 32'h3E000000, 32'h00080000, 32'h7F800000};
        sd = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        base = n_out;
        i = 0;
        for (int c = 0; c < 30; c++) begin
            if (i < 6)
                cycle(1'b1, sd[i], sv[i], !(c >= 3 && c < 6), 1'b0, 32'h0, 1'b0, 1'b0, acc, ir);
            else
                cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, acc, ir);
            if (c == 4) chk("stall_rdy_low", 32'(ir), 32'd0);
            if (c == 6) chk("stall_rdy_back", 32'(ir), 32'd1);
            if (acc) i++;
        end
        chk("stream_sent", 32'(i), 32'd6);
        drain();
        chk("stream_count", 32'(n_out - base), 32'd6);

        // reset with two transactions in flight
        cycle(1'b1, 1'b0, 32'h3FC00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, acc, ir);
        cycle(1'b1, 1'b0, 32'hBE800000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, acc, ir);
        @(negedge clk);
        in_valid_i = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid_o), 32'd0);
        chk("midrst_data", data_o, 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        out_ready_i = 1'b1;
        rst_n       = 1'b1;
        base = n_out;
        send(1'b0, 32'h40000000, 1'b1, 32'h000FFFFF, 1'b1, 1'b0);
        send(1'b1, 32'h000C0000, 1'b1, 32'h3FC00000, 1'b0, 1'b0);
        drain();
        chk("post_rst_count", 32'(n_out - base), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
